// File: rtl/iob_cache_arb_pkg.sv
// Shared types and helpers for the iob_cache front-end arbiter.
// Build option: define IOB_CACHE_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
package iob_cache_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Word address width seen by the cache for a given byte address and data width.
  function automatic int wa_w(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

  function automatic int onehot2idx(input logic [31:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/iob_cache_arb_sel.sv
// Combinational winner selection for iob_cache_arbiter.
// IOB_CACHE_ARB_RR_EN selects round-robin from last+1; otherwise lowest valid index wins.
module iob_cache_arb_sel #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] winner
);

`ifdef IOB_CACHE_ARB_RR_EN
  // Scan from the farthest offset down so the nearest valid index after last wins.
  always_comb begin
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last) + k) % N_REQ]) begin
        winner = '0;
        winner[(int'(last) + k) % N_REQ] = 1'b1;
      end
    end
  end
`else
  assign winner = req_valid & (~req_valid + 1'b1);

  logic unused_last;
  assign unused_last = ^last;
`endif

endmodule

// File: rtl/iob_cache_arbiter.sv
// Shares one iob_cache native front-end port between N_REQ requesters, one transaction at a time.
// Build option: IOB_CACHE_ARB_RR_EN enables round-robin arbitration (default fixed priority, index 0 highest).
module iob_cache_arbiter
  import iob_cache_arb_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int N_REQ  = 2,
  localparam int WA_W   = wa_w(ADDR_W, DATA_W),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WA_W-1:0]      req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*STRB_W-1:0]    req_wstrb,
  output logic [N_REQ*DATA_W-1:0]    req_rdata,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       c_valid,
  output logic [WA_W-1:0]            c_addr,
  output logic [DATA_W-1:0]          c_wdata,
  output logic [STRB_W-1:0]          c_wstrb,
  input  logic [DATA_W-1:0]          c_rdata,
  input  logic                       c_ready
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t         state;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   winner;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win_idx;
  logic [WA_W-1:0]    hold_addr;
  logic [DATA_W-1:0]  hold_wdata;
  logic [STRB_W-1:0]  hold_wstrb;
  logic [WA_W-1:0]    sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;

  iob_cache_arb_sel #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_valid (req_valid),
    .last      (last),
    .winner    (winner)
  );

  assign win_idx   = IDX_W'(onehot2idx(32'(winner)));
  assign sel_addr  = req_addr[win_idx*WA_W +: WA_W];
  assign sel_wdata = req_wdata[win_idx*DATA_W +: DATA_W];
  assign sel_wstrb = req_wstrb[win_idx*STRB_W +: STRB_W];

  assign req_rdata = {N_REQ{c_rdata}};

  // IDLE passes the winner straight through; BUSY replays the captured request.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    c_valid   = 1'b0;
    c_addr    = '0;
    c_wdata   = '0;
    c_wstrb   = '0;
    req_ready = '0;
    case (state)
      ARB_IDLE: begin
        if (|req_valid) begin
          c_valid = 1'b1;
          c_addr  = sel_addr;
          c_wdata = sel_wdata;
          c_wstrb = sel_wstrb;
        end
      end
      ARB_BUSY: begin
        c_valid = 1'b1;
        c_addr  = hold_addr;
        c_wdata = hold_wdata;
        c_wstrb = hold_wstrb;
        if (c_ready) req_ready = gnt;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      last       <= IDX_W'(N_REQ - 1);
      // NOTE: hold registers are reset so the cache port never shows X after power-up.
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            state      <= ARB_BUSY;
            gnt        <= winner;
            last       <= win_idx;
            hold_addr  <= sel_addr;
            hold_wdata <= sel_wdata;
            hold_wstrb <= sel_wstrb;
          end
        end
        ARB_BUSY: begin
          if (c_ready) begin
            state <= ARB_IDLE;
            gnt   <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A ready pulse with nothing outstanding means the cache broke the handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(state == ARB_IDLE && c_ready))
        else $warning("iob_cache_arbiter: c_ready pulsed while idle, ignored");
    end
  end
`endif

endmodule

// File: tb/tb_iob_cache_arbiter.sv
// Directed bench for iob_cache_arbiter with a two-cycle behavioural cache model.
// Expectations follow IOB_CACHE_ARB_RR_EN when it is defined for the build.
module tb_iob_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int N_REQ  = 2;
  localparam int WA_W   = 30;
  localparam int STRB_W = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WA_W-1:0]   req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ*DATA_W-1:0] req_rdata;
  logic [N_REQ-1:0]        req_ready;
  logic                    c_valid;
  logic [WA_W-1:0]         c_addr;
  logic [DATA_W-1:0]       c_wdata;
  logic [STRB_W-1:0]       c_wstrb;
  logic [DATA_W-1:0]       c_rdata;
  logic                    c_ready;
  logic                    model_ready;
  logic                    spur_ready;

  int checks = 0;
  int errors = 0;
  int cyc;

  assign c_ready = model_ready | spur_ready;

  always #5 clk = ~clk;

  iob_cache_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_REQ  (N_REQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_rdata (req_rdata),
    .req_ready (req_ready),
    .c_valid   (c_valid),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_wstrb   (c_wstrb),
    .c_rdata   (c_rdata),
    .c_ready   (c_ready)
  );

  // Cache model: ready two cycles after valid rises; unwritten words read as A000_0000 + addr.
  logic [31:0] mem [int];
  int          mcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_ready <= 1'b0;
      mcnt        <= 0;
      c_rdata     <= '0;
      cyc         <= 0;
    end else begin
      cyc <= cyc + 1;
      if (model_ready) begin
        model_ready <= 1'b0;
        mcnt        <= 0;
      end else if (c_valid) begin
        if (mcnt == 1) begin
          logic [31:0] word;
          word = mem.exists(int'(c_addr)) ? mem[int'(c_addr)] : (32'hA000_0000 + 32'(c_addr));
          c_rdata     <= word;
          model_ready <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (c_wstrb[b]) word[8*b +: 8] = c_wdata[8*b +: 8];
          end
          if (c_wstrb != 4'h0) mem[int'(c_addr)] = word;
        end
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [WA_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[i]                 = v;
    req_addr[i*WA_W +: WA_W]     = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_wstrb[i*STRB_W +: STRB_W] = s;
  endtask

  // Bounded wait for a ready pulse; who stays 0 on timeout so the caller's check fails.
  task automatic wait_ready(output logic [1:0] who, output logic [31:0] data, output int at);
    who  = 2'b00;
    data = '0;
    at   = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (req_ready != 2'b00) begin
        who  = req_ready;
        data = req_ready[1] ? req_rdata[63:32] : req_rdata[31:0];
        at   = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]      valid;
    logic [WA_W-1:0] a0, a1;
    logic [31:0]     d0, d1;
    logic [3:0]      s0, s1;
    logic            exp_v;
    logic [WA_W-1:0] exp_a;
    logic [31:0]     exp_d;
    logic [3:0]      exp_s;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  who, who2;
    logic [31:0] data, data2;
    int          t1, t2, t0, prev, n1;
    logic [1:0]  exp_who;

    vecs[0] = '{2'b00, 30'h7, 30'h9, 32'h1111, 32'h2222, 4'hF, 4'h3, 1'b0, 30'h0, 32'h0, 4'h0};
    vecs[1] = '{2'b01, 30'h4, 30'h8, 32'hDEAD, 32'h0, 4'hF, 4'h0, 1'b1, 30'h4, 32'hDEAD, 4'hF};
    vecs[2] = '{2'b10, 30'h4, 30'h10, 32'hDEAD, 32'h0, 4'hF, 4'h0, 1'b1, 30'h10, 32'h0, 4'h0};
    vecs[3] = '{2'b11, 30'h4, 30'h8, 32'hDEAD, 32'h1234, 4'hF, 4'h3, 1'b1, 30'h4, 32'hDEAD, 4'hF};
    vecs[4] = '{2'b10, 30'h0, 30'h3FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 4'h0, 4'hF,
                1'b1, 30'h3FFF_FFFF, 32'hFFFF_FFFF, 4'hF};

    reset      = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    spur_ready = 1'b0;
    #1;
    check("reset_c_valid", 64'(c_valid), 64'h0);
    check("reset_c_addr", 64'(c_addr), 64'h0);
    check("reset_c_wdata", 64'(c_wdata), 64'h0);
    check("reset_req_ready", 64'(req_ready), 64'h0);
    step();
    step();
    reset = 1'b0;

    // Combinational pass-through in IDLE; valid is dropped before each edge so no grant happens.
    for (int i = 0; i < 5; i++) begin
      req_valid = vecs[i].valid;
      req_addr  = {vecs[i].a1, vecs[i].a0};
      req_wdata = {vecs[i].d1, vecs[i].d0};
      req_wstrb = {vecs[i].s1, vecs[i].s0};
      #1;
      check($sformatf("vec%0d_c_valid", i), 64'(c_valid), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d_c_addr", i), 64'(c_addr), 64'(vecs[i].exp_a));
      check($sformatf("vec%0d_c_wdata", i), 64'(c_wdata), 64'(vecs[i].exp_d));
      check($sformatf("vec%0d_c_wstrb", i), 64'(c_wstrb), 64'(vecs[i].exp_s));
      check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'h0);
      req_valid = '0;
      step();
    end

    // Single read from requester 1.
    set_req(1, 1'b1, 30'h10, 32'h0, 4'h0);
    t0 = cyc;
    #1;
    check("single_c_valid", 64'(c_valid), 64'h1);
    check("single_c_addr", 64'(c_addr), 64'h10);
    wait_ready(who, data, t1);
    req_valid[1] = 1'b0;
    check("single_who", 64'(who), 64'h2);
    check("single_rdata", 64'(data), 64'hA000_0010);
    check("single_rdata_slot0", 64'(req_rdata[31:0]), 64'hA000_0010);
    check("single_latency", 64'(t1 - t0), 64'd2);
    step();
    check("single_pulse_width", 64'(req_ready), 64'h0);

    // Simultaneous write from req0 and read from req1: req0 first, one bubble, then req1.
    set_req(0, 1'b1, 30'h4, 32'hDEAD, 4'hF);
    set_req(1, 1'b1, 30'h8, 32'h0, 4'h0);
    wait_ready(who, data, t1);
    req_valid[0] = 1'b0;
    check("conflict_first", 64'(who), 64'h1);
    wait_ready(who2, data2, t2);
    req_valid[1] = 1'b0;
    check("conflict_second", 64'(who2), 64'h2);
    check("conflict_rdata", 64'(data2), 64'hA000_0008);
    check("conflict_gap", 64'(t2 - t1), 64'd3);
    step();

    // Request is held stable even when the requester changes its address.
    set_req(0, 1'b1, 30'h4, 32'h0, 4'h0);
    step();
    check("hold_grant_addr", 64'(c_addr), 64'h4);
    req_addr[WA_W-1:0] = 30'h20;
    who = 2'b00;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_addr", 64'(c_addr), 64'h4);
      if (req_ready != 2'b00) begin
        who  = req_ready;
        data = req_rdata[31:0];
        break;
      end
    end
    req_valid[0] = 1'b0;
    check("hold_who", 64'(who), 64'h1);
    check("hold_rdata", 64'(data), 64'h0000_DEAD);
    step();

    // Asynchronous reset while BUSY drops the transaction; the reissue completes.
    set_req(0, 1'b1, 30'h4, 32'h0, 4'h0);
    step();
    check("rst_busy_c_valid", 64'(c_valid), 64'h1);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("rst_c_valid", 64'(c_valid), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    step();
    check("rst_hold_req_ready", 64'(req_ready), 64'h0);
    check("rst_hold_c_valid", 64'(c_valid), 64'h0);
    reset = 1'b0;
    set_req(0, 1'b1, 30'h4, 32'h0, 4'h0);
    wait_ready(who, data, t1);
    req_valid[0] = 1'b0;
    check("rst_reissue_who", 64'(who), 64'h1);
    check("rst_reissue_rdata", 64'(data), 64'h0000_DEAD);
    step();

    // Both requesters continuously valid for 20 transactions.
    set_req(0, 1'b1, 30'h20, 32'h0, 4'h0);
    set_req(1, 1'b1, 30'h8, 32'h0, 4'h0);
    n1   = 0;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      wait_ready(who, data, t1);
      if (who == 2'b10) n1++;
`ifdef IOB_CACHE_ARB_RR_EN
      exp_who = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_who = 2'b01;
`endif
      check($sformatf("stream%0d_who", i), 64'(who), 64'(exp_who));
      if (i > 0) check($sformatf("stream%0d_gap", i), 64'(t1 - prev), 64'd3);
      prev = t1;
    end
    req_valid = '0;
`ifdef IOB_CACHE_ARB_RR_EN
    check("stream_req1_grants", 64'(n1), 64'd10);
`else
    check("stream_req1_grants", 64'(n1), 64'd0);
`endif
    step();
    step();

    // Spurious c_ready while idle is ignored.
    spur_ready = 1'b1;
    #1;
    check("spurious_req_ready", 64'(req_ready), 64'h0);
    check("spurious_c_valid", 64'(c_valid), 64'h0);
    step();
    spur_ready = 1'b0;
    #1;
    check("spurious_after_req_ready", 64'(req_ready), 64'h0);
    check("spurious_after_c_valid", 64'(c_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
